// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-memory address and registers the returned word into IF/ID.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0,
  parameter int PROG_LEN = 27
) (
  input  logic              Clk,
  input  logic              Rst_n,
  output logic [ADDR_W-1:0] ImAddress,
  input  logic [DATA_W-1:0] ImReadData,
  output logic              IfValid,
  input  logic              IdReady,
  output logic [DATA_W-1:0] IfInstr,
  output logic [ADDR_W-1:0] IfPC,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC,
  output logic              Done
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]       FetchCount,
  output logic [15:0]       StallCount
`endif
);

  localparam int                LAST_IDX   = PROG_LEN - 1;
  localparam logic [ADDR_W-1:0] LAST_PC    = LAST_IDX[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   PROG_LEN_W = PROG_LEN[ADDR_W:0];
  localparam logic [ADDR_W-1:0] RST_PC     = RESET_PC[ADDR_W-1:0];

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc_p0, pc_nxt;
  logic                vld_p1, vld_nxt;
  logic [DATA_W-1:0]   instr_p1;
  logic [ADDR_W-1:0]   pc_p1;
  logic                done_p1, done_nxt;
  logic                load;
  logic                in_range;

  assign in_range = ({1'b0, pc_p0} < PROG_LEN_W);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    vld_nxt   = vld_p1;
    load      = 1'b0;
    if (Redirect) begin
      state_nxt = RUN;
      pc_nxt    = RedirectPC;
      vld_nxt   = 1'b0;
    end else begin
      if (vld_p1 && IdReady) vld_nxt = 1'b0;
      if (state == RUN) begin
        // An out-of-image PC (only reachable by redirect) halts without fetching.
        if (!in_range) begin
          state_nxt = HALT;
        end else if (!vld_p1 || IdReady) begin
          load    = 1'b1;
          vld_nxt = 1'b1;
          pc_nxt  = pc_p0 + 1'b1;
          if (pc_p0 == LAST_PC) state_nxt = HALT;
        end
      end
    end
    done_nxt = (state_nxt == HALT) && !vld_nxt;
  end

  // p0: program counter and FSM state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= RUN;
      pc_p0 <= RST_PC;
    end else begin
      state <= state_nxt;
      pc_p0 <= pc_nxt;
    end
  end

  // p1: IF/ID output register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
      done_p1  <= 1'b0;
    end else begin
      vld_p1  <= vld_nxt;
      done_p1 <= done_nxt;
      if (load) begin
        instr_p1 <= ImReadData;
        pc_p1    <= pc_p0;
      end
    end
  end

  assign ImAddress = pc_p0;
  assign IfValid   = vld_p1;
  assign IfInstr   = instr_p1;
  assign IfPC      = pc_p1;
  assign Done      = done_p1;

`ifdef IFU_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (load)               FetchCount <= sat_inc(FetchCount);
      if (vld_p1 && !IdReady) StallCount <= sat_inc(StallCount);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus a randomized run against a stream-level model.
module tb_instruction_fetch_unit;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int PROG_LEN = 27;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic [ADDR_W-1:0] ImAddress;
  logic [DATA_W-1:0] ImReadData;
  logic              IfValid;
  logic              IdReady = 1'b0;
  logic [DATA_W-1:0] IfInstr;
  logic [ADDR_W-1:0] IfPC;
  logic              Redirect = 1'b0;
  logic [ADDR_W-1:0] RedirectPC = '0;
  logic              Done;
`ifdef IFU_PERF_CNT_EN
  logic [15:0]       FetchCount;
  logic [15:0]       StallCount;
`endif

  logic [DATA_W-1:0] im [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  assign ImReadData = im[ImAddress];

  always #5 Clk = ~Clk;

  instruction_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0), .PROG_LEN(PROG_LEN)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ImAddress(ImAddress), .ImReadData(ImReadData),
    .IfValid(IfValid), .IdReady(IdReady), .IfInstr(IfInstr), .IfPC(IfPC),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .Done(Done)
`ifdef IFU_PERF_CNT_EN
    , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
  );

  task automatic do_reset();
    Rst_n = 1'b0; Redirect = 1'b0; RedirectPC = '0; IdReady = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; IdReady = 1'b0; Redirect = 1'b0;
    @(negedge Clk);
    n_checks++; if (ImAddress !== 6'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", ImAddress); end
    n_checks++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", IfValid); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_checks++; if (IfInstr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", IfInstr); end
    IdReady = 1'b1; Rst_n = 1'b1;
    @(negedge Clk);
    n_checks++; if (IfValid !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", IfValid); end
    n_checks++; if (IfPC !== 6'd0) begin n_fail++; $display("FAIL first_pc got %0d want 0", IfPC); end
    n_checks++; if (IfInstr !== 32'h80088014) begin n_fail++; $display("FAIL first_instr got %h want 80088014", IfInstr); end
    n_checks++; if (ImAddress !== 6'd1) begin n_fail++; $display("FAIL first_addr got %0d want 1", ImAddress); end
  endtask

  task automatic test_free_run();
    int exp_pc, first, last;
    do_reset();
    IdReady = 1'b1; Rst_n = 1'b1;
    exp_pc = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (IfValid) begin
        n_checks++; if (int'(IfPC) !== exp_pc) begin n_fail++; $display("FAIL run_pc got %0d want %0d", IfPC, exp_pc); end
        n_checks++; if (IfInstr !== im[exp_pc]) begin n_fail++; $display("FAIL run_instr got %h want %h", IfInstr, im[exp_pc]); end
        if (first < 0) first = c;
        last = c;
        exp_pc++;
      end
    end
    n_checks++; if (exp_pc !== PROG_LEN) begin n_fail++; $display("FAIL run_handshakes got %0d want %0d", exp_pc, PROG_LEN); end
    n_checks++; if (last - first !== PROG_LEN - 1) begin n_fail++; $display("FAIL run_span got %0d want %0d", last - first, PROG_LEN - 1); end
    n_checks++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL run_end_valid got %b want 0", IfValid); end
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL run_done got %b want 1", Done); end
  endtask

  task automatic test_stall_redirect();
    bit found;
    do_reset();
    IdReady = 1'b1; Rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge Clk);
      if (IfValid && IfPC == 6'd4) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stall_reach got no pc4 want pc4"); end
    IdReady = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      n_checks++; if (IfValid !== 1'b1) begin n_fail++; $display("FAIL stall_valid got %b want 1", IfValid); end
      n_checks++; if (IfPC !== 6'd4) begin n_fail++; $display("FAIL stall_pc got %0d want 4", IfPC); end
      n_checks++; if (IfInstr !== im[4]) begin n_fail++; $display("FAIL stall_instr got %h want %h", IfInstr, im[4]); end
      n_checks++; if (ImAddress !== 6'd5) begin n_fail++; $display("FAIL stall_addr got %0d want 5", ImAddress); end
    end
`ifdef IFU_PERF_CNT_EN
    n_checks++; if (StallCount !== 16'd3) begin n_fail++; $display("FAIL stall_cnt got %0d want 3", StallCount); end
    n_checks++; if (FetchCount !== 16'd5) begin n_fail++; $display("FAIL stall_fetch got %0d want 5", FetchCount); end
`endif
    Redirect = 1'b1; RedirectPC = 6'd12;
    @(negedge Clk);
    Redirect = 1'b0; IdReady = 1'b1;
    n_checks++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", IfValid); end
    n_checks++; if (ImAddress !== 6'd12) begin n_fail++; $display("FAIL redir_addr got %0d want 12", ImAddress); end
    @(negedge Clk);
    n_checks++; if (IfValid !== 1'b1) begin n_fail++; $display("FAIL redir_valid2 got %b want 1", IfValid); end
    n_checks++; if (IfPC !== 6'd12) begin n_fail++; $display("FAIL redir_pc got %0d want 12", IfPC); end
    n_checks++; if (IfInstr !== im[12]) begin n_fail++; $display("FAIL redir_instr got %h want %h", IfInstr, im[12]); end
`ifdef IFU_PERF_CNT_EN
    n_checks++; if (FetchCount !== 16'd6) begin n_fail++; $display("FAIL redir_fetch got %0d want 6", FetchCount); end
    n_checks++; if (StallCount !== 16'd4) begin n_fail++; $display("FAIL redir_stall got %0d want 4", StallCount); end
`endif
  endtask

  task automatic test_halt_redirect();
    int exp_pc;
    bit done_seen;
    do_reset();
    IdReady = 1'b1; Rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      @(negedge Clk);
      if (Done) done_seen = 1'b1;
    end
    n_checks++; if (!done_seen) begin n_fail++; $display("FAIL halt_reach got done=0 want 1"); end
    Redirect = 1'b1; RedirectPC = 6'd0;
    @(negedge Clk);
    Redirect = 1'b0;
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL replay_done_clr got %b want 0", Done); end
    n_checks++; if (ImAddress !== 6'd0) begin n_fail++; $display("FAIL replay_addr got %0d want 0", ImAddress); end
    exp_pc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (IfValid) begin
        n_checks++; if (int'(IfPC) !== exp_pc) begin n_fail++; $display("FAIL replay_pc got %0d want %0d", IfPC, exp_pc); end
        n_checks++; if (IfInstr !== im[exp_pc]) begin n_fail++; $display("FAIL replay_instr got %h want %h", IfInstr, im[exp_pc]); end
        exp_pc++;
      end
    end
    n_checks++; if (exp_pc !== PROG_LEN) begin n_fail++; $display("FAIL replay_count got %0d want %0d", exp_pc, PROG_LEN); end
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL replay_done got %b want 1", Done); end
`ifdef IFU_PERF_CNT_EN
    n_checks++; if (FetchCount !== 16'd54) begin n_fail++; $display("FAIL replay_fetch got %0d want 54", FetchCount); end
`endif
    Redirect = 1'b1; RedirectPC = 6'd40;
    @(negedge Clk);
    Redirect = 1'b0;
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL oob_done1 got %b want 0", Done); end
    n_checks++; if (ImAddress !== 6'd40) begin n_fail++; $display("FAIL oob_addr got %0d want 40", ImAddress); end
    @(negedge Clk);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL oob_done2 got %b want 1", Done); end
    n_checks++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL oob_valid got %b want 0", IfValid); end
    n_checks++; if (ImAddress !== 6'd40) begin n_fail++; $display("FAIL oob_addr2 got %0d want 40", ImAddress); end
`ifdef IFU_PERF_CNT_EN
    n_checks++; if (FetchCount !== 16'd54) begin n_fail++; $display("FAIL oob_fetch got %0d want 54", FetchCount); end
`endif
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    IdReady = 1'b1; Rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge Clk);
      if (IfValid && IfPC == 6'd9) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL areset_reach got no pc9 want pc9"); end
    #2 Rst_n = 1'b0;
    #1;
    n_checks++; if (IfValid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got %b want 0", IfValid); end
    n_checks++; if (ImAddress !== 6'd0) begin n_fail++; $display("FAIL areset_addr got %0d want 0", ImAddress); end
    n_checks++; if (IfInstr !== 32'd0) begin n_fail++; $display("FAIL areset_instr got %h want 0", IfInstr); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL areset_done got %b want 0", Done); end
`ifdef IFU_PERF_CNT_EN
    n_checks++; if (FetchCount !== 16'd0) begin n_fail++; $display("FAIL areset_fetch got %0d want 0", FetchCount); end
    n_checks++; if (StallCount !== 16'd0) begin n_fail++; $display("FAIL areset_stall got %0d want 0", StallCount); end
`endif
    @(negedge Clk);
  endtask

  // Model: the handshake stream must be im[exp_pc], im[exp_pc+1], ... restarting at each redirect target.
  task automatic test_random();
    int exp_pc, since, target;
    bit exp_valid, exp_done, redir;
    do_reset();
    Rst_n = 1'b1;
    exp_pc = 0; since = 100; target = 0;
    for (int i = 0; i < 600; i++) begin
      redir = ($urandom_range(0, 99) < 6);
      IdReady = ($urandom_range(0, 99) < 70);
      Redirect = redir;
      if (redir) begin
        target = $urandom_range(0, 40);
        RedirectPC = target[ADDR_W-1:0];
        exp_pc = target;
        since = 1;
      end else begin
        if (IfValid && IdReady) exp_pc++;
        since++;
      end
      @(negedge Clk);
      Redirect = 1'b0;
      exp_valid = (since >= 2) && (exp_pc < PROG_LEN);
      exp_done  = (since >= 2) && (exp_pc >= PROG_LEN);
      n_checks++; if (IfValid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, IfValid, exp_valid); end
      n_checks++; if (Done !== exp_done) begin n_fail++; $display("FAIL rnd_done cyc %0d got %b want %b", i, Done, exp_done); end
      if (since == 1) begin
        n_checks++; if (int'(ImAddress) !== target) begin n_fail++; $display("FAIL rnd_redir_addr cyc %0d got %0d want %0d", i, ImAddress, target); end
      end
      if (IfValid && exp_valid) begin
        n_checks++; if (int'(IfPC) !== exp_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %0d want %0d", i, IfPC, exp_pc); end
        n_checks++; if (IfInstr !== im[exp_pc]) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %h want %h", i, IfInstr, im[exp_pc]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) im[i] = $urandom;
    im[0]  = 32'h80088014;
    im[7]  = 32'd0;
    im[13] = 32'd0;
    test_reset();
    test_free_run();
    test_stall_redirect();
    test_halt_redirect();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
